// File: rtl/bit_alloc_pool_pkg.sv
// Shared helpers for the bit-vector allocators: count-width derivation and popcount.
package bit_alloc_pool_pkg;

  // Widest vector popcount() accepts; narrower vectors are zero-extended by the caller.
  localparam int POP_MAX = 256;

  // Bits needed to hold a count from 0 to n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Number of set bits in a (zero-extended) vector.
  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < POP_MAX; i++) begin
      c += {31'b0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/bit_alloc_pool_pick.sv
// Chained find-first-set: each requesting port, in ascending order, takes the
// lowest entry still available after the picks of the ports before it.
module bit_alloc_pool_pick #(
  parameter int WIDTH = 32,
  parameter int NPORT = 4
) (
  input  logic [WIDTH-1:0]       mask,
  input  logic [NPORT-1:0]       req,
  output logic [NPORT*WIDTH-1:0] pick
);

  logic [WIDTH-1:0] avail;
  logic [WIDTH-1:0] lowest;

  // Walk the ports; a stage consumes its pick from the mask only when it requests.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves one
    // unassigned, which would otherwise infer a latch.
    avail  = mask;
    lowest = '0;
    pick   = '0;
    for (int k = 0; k < NPORT; k++) begin
      lowest = avail & (~avail + WIDTH'(1));
      if (req[k]) begin
        pick[k*WIDTH +: WIDTH] = lowest;
        avail                  = avail & ~lowest;
      end
    end
  end

endmodule

// File: rtl/bit_alloc_pool.sv
// Registered free-list allocator: multi-port one-hot grants from the free mask,
// all-or-nothing stall, returned entries, free count and sticky double-free flag.
module bit_alloc_pool
  import bit_alloc_pool_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NPORT = 4,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clkEn,
  input  logic                   flush,
  input  logic [NPORT-1:0]       req,
  output logic [NPORT*WIDTH-1:0] grant,
  output logic                   doStall,
  input  logic [WIDTH-1:0]       free_bits,
  output logic [CW-1:0]          free_cnt,
  output logic                   dbl_free
);

  logic [WIDTH-1:0]       free_mask;
  logic [WIDTH-1:0]       alloc_vec;
  logic [NPORT*WIDTH-1:0] pick;
  logic [CW-1:0]          next_cnt;
  logic                   grant_en;
  int unsigned            nreq;

  bit_alloc_pool_pick #(
    .WIDTH (WIDTH),
    .NPORT (NPORT)
  ) u_pick (
    .mask (free_mask),
    .req  (req),
    .pick (pick)
  );

  // Stall when more ports ask than entries are free; independent of clkEn and flush.
  always_comb begin
    nreq    = popcount(POP_MAX'(req));
    doStall = nreq > 32'(free_cnt);
  end

  assign grant_en = clkEn & ~doStall & ~flush;

  // Gate the picks into grants and merge them into the vector that commits.
  always_comb begin
    grant     = '0;
    alloc_vec = '0;
    for (int k = 0; k < NPORT; k++) begin
      grant[k*WIDTH +: WIDTH] = pick[k*WIDTH +: WIDTH] & {WIDTH{grant_en & req[k]}};
      alloc_vec               = alloc_vec | grant[k*WIDTH +: WIDTH];
    end
  end

  // A bit both allocated and freed stays free, so it is not subtracted; a bit
  // freed while already free is not added. Keeps the count equal to the mask.
  always_comb begin
    next_cnt = free_cnt
             - CW'(popcount(POP_MAX'(alloc_vec & ~free_bits)))
             + CW'(popcount(POP_MAX'(free_bits & ~free_mask)));
  end

  // Commit allocations and frees; flush restores a fully free pool.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      free_mask <= '1;
      free_cnt  <= CW'(WIDTH);
      dbl_free  <= 1'b0;
    end else if (flush) begin
      free_mask <= '1;
      free_cnt  <= CW'(WIDTH);
    end else begin
      free_mask <= (free_mask & ~alloc_vec) | free_bits;
      free_cnt  <= next_cnt;
      if (|(free_bits & free_mask)) begin
        dbl_free <= 1'b1;
      end
    end
  end

  // The registered count always matches the mask it summarises.
  a_cnt_matches_mask : assert property (
    @(posedge clk) disable iff (!rst) 32'(free_cnt) == popcount(POP_MAX'(free_mask))
  );

endmodule

// File: tb/tb_bit_alloc_pool.sv
// Randomised + directed bench for bit_alloc_pool: stimulus pushes predicted
// outputs into a scoreboard queue, a monitor pops and compares on the falling edge.
module tb_bit_alloc_pool;

  localparam int WIDTH = 32;
  localparam int NPORT = 4;
  localparam int CW    = 6;
  localparam int GW    = NPORT * WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             clkEn;
  logic             flush;
  logic [NPORT-1:0] req;
  logic [GW-1:0]    grant;
  logic             doStall;
  logic [WIDTH-1:0] free_bits;
  logic [CW-1:0]    free_cnt;
  logic             dbl_free;

  bit_alloc_pool #(
    .WIDTH (WIDTH),
    .NPORT (NPORT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clkEn     (clkEn),
    .flush     (flush),
    .req       (req),
    .grant     (grant),
    .doStall   (doStall),
    .free_bits (free_bits),
    .free_cnt  (free_cnt),
    .dbl_free  (dbl_free)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [GW-1:0] grant;
    logic          stall;
    logic [CW-1:0] cnt;
    logic          dbl;
    string         tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: which entries are free, and the sticky error flag.
  bit fm[WIDTH];
  bit m_dbl;

  // Inputs in force for the current cycle and the grants predicted for them.
  logic             cur_rst;
  logic             cur_ce;
  logic             cur_fl;
  logic [NPORT-1:0] cur_req;
  logic [WIDTH-1:0] cur_fb;
  logic [GW-1:0]    cur_grant;

  task automatic check(input string name, input logic [GW-1:0] got, input logic [GW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int free_count();
    int c = 0;
    for (int i = 0; i < WIDTH; i++) c += int'(fm[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < WIDTH; i++) fm[i] = 1'b1;
    m_dbl = 1'b0;
  endtask

  // Outputs expected between edges for the current model state and inputs.
  function automatic exp_t predict();
    exp_t e;
    int   nreq = 0;
    int   idx  = 0;
    e.grant = '0;
    e.cnt   = CW'(free_count());
    e.dbl   = m_dbl;
    for (int k = 0; k < NPORT; k++) nreq += int'(cur_req[k]);
    e.stall = nreq > free_count();
    if (cur_ce && !cur_fl && !e.stall) begin
      for (int k = 0; k < NPORT; k++) begin
        if (cur_req[k]) begin
          while (idx < WIDTH && !fm[idx]) idx++;
          if (idx < WIDTH) e.grant[k*WIDTH + idx] = 1'b1;
          idx++;
        end
      end
    end
    return e;
  endfunction

  // State update on a rising edge with the inputs that were in force.
  task automatic model_commit();
    if (!cur_rst) begin
      model_reset();
    end else if (cur_fl) begin
      for (int i = 0; i < WIDTH; i++) fm[i] = 1'b1;
    end else begin
      for (int i = 0; i < WIDTH; i++) if (cur_fb[i] && fm[i]) m_dbl = 1'b1;
      for (int k = 0; k < NPORT; k++)
        for (int i = 0; i < WIDTH; i++) if (cur_grant[k*WIDTH + i]) fm[i] = 1'b0;
      for (int i = 0; i < WIDTH; i++) if (cur_fb[i]) fm[i] = 1'b1;
    end
  endtask

  task automatic drive(input logic r, input logic ce, input logic fl,
                       input logic [NPORT-1:0] rq, input logic [WIDTH-1:0] fb,
                       input string tag);
    exp_t e;
    cur_rst = r;  cur_ce = ce;  cur_fl = fl;  cur_req = rq;  cur_fb = fb;
    rst = r;  clkEn = ce;  flush = fl;  req = rq;  free_bits = fb;
    if (!r) model_reset();
    e         = predict();
    e.tag     = tag;
    cur_grant = e.grant;
    sb.push_back(e);
  endtask

  task automatic step(input logic ce, input logic fl, input logic [NPORT-1:0] rq,
                      input logic [WIDTH-1:0] fb, input string tag);
    @(posedge clk);
    model_commit();
    #1;
    drive(1'b1, ce, fl, rq, fb, tag);
  endtask

  task automatic rand_step(input string tag);
    logic [WIDTH-1:0] fb;
    @(posedge clk);
    model_commit();
    #1;
    fb = '0;
    for (int i = 0; i < WIDTH; i++) if (!fm[i] && $urandom_range(3) == 0) fb[i] = 1'b1;
    if ($urandom_range(49) == 0) fb[$urandom_range(WIDTH-1)] = 1'b1;
    drive(1'b1, $urandom_range(9) != 0, $urandom_range(31) == 0, NPORT'($urandom), fb, tag);
  endtask

  // Reset asserted and released away from the clock edges.
  task automatic mid_reset();
    @(posedge clk);
    model_commit();
    #3;
    drive(1'b0, 1'b0, 1'b0, '0, '0, "async_reset");
    @(posedge clk);
    model_commit();
    #3;
    drive(1'b1, 1'b0, 1'b0, '0, '0, "reset_release");
  endtask

  // Monitor: compare DUT outputs with the oldest prediction on each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, ".grant"},    grant,           e.grant);
        check({e.tag, ".doStall"},  GW'(doStall),    GW'(e.stall));
        check({e.tag, ".free_cnt"}, GW'(free_cnt),   GW'(e.cnt));
        check({e.tag, ".dbl_free"}, GW'(dbl_free),   GW'(e.dbl));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d predictions pending", sb.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;  clkEn = 1'b0;  flush = 1'b0;  req = '0;  free_bits = '0;
    cur_grant = '0;
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, "in_reset");
    @(posedge clk);
    model_commit();
    #1;
    drive(1'b1, 1'b0, 1'b0, '0, '0, "idle");

    step(1'b0, 1'b0, 4'b0000, '0, "idle2");
    step(1'b1, 1'b0, 4'b1111, '0, "alloc_1111");
    step(1'b1, 1'b0, 4'b1010, '0, "alloc_1010");
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 4'b1111, '0, "drain_to_2");
    step(1'b1, 1'b0, 4'b0111, '0, "stall_3_of_2");
    step(1'b1, 1'b0, 4'b0011, '0, "alloc_last_2");
    step(1'b1, 1'b0, 4'b0001, 32'h1, "free_not_bypassed");
    step(1'b1, 1'b0, 4'b0001, '0, "regrant_bit0");
    step(1'b1, 1'b0, 4'b0000, 32'h1, "free_bit0");
    step(1'b1, 1'b0, 4'b0000, 32'h1, "double_free_bit0");
    step(1'b1, 1'b0, 4'b0000, '0, "dbl_sticky");
    step(1'b1, 1'b1, 4'b1111, '0, "flush_with_req");
    step(1'b1, 1'b0, 4'b0000, '0, "after_flush");
    step(1'b0, 1'b0, 4'b1111, '0, "clken_low");

    for (int i = 0; i < 300; i++) rand_step("random_a");
    mid_reset();
    for (int i = 0; i < 100; i++) rand_step("random_b");

    @(posedge clk);
    model_commit();
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
